// File: rtl/mac_stack_pkg.sv
// ---------------------------------------------------------------------------
// mac_stack_pkg
// Shared constants for the MAC TX stack:
//   - ethertypes for the IP and ARP layers
//   - mac_tx_arbiter FSM state encoding
//   - requester index constants used by the round-robin arbiter
// ---------------------------------------------------------------------------
package mac_stack_pkg;

    localparam logic [15:0] P_TYPE_IP  = 16'h0800;
    localparam logic [15:0] P_TYPE_ARP = 16'h0806;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic REQ_IP  = 1'b0;
    localparam logic REQ_ARP = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick between IP and ARP with a last-served pointer.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_ip/arp     request levels
//   i_update         1-cycle pulse: record i_served as the last-served side
//   i_served         requester index that just finished its frame
//   o_winner         requester index that would win now (valid when any req)
// ---------------------------------------------------------------------------
module rr_arb2
    import mac_stack_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_ip,
    input  logic i_req_arp,
    input  logic i_update,
    input  logic i_served,
    output logic o_winner
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (i_update) begin
            last_d = i_served;
        end
    end

    // On a tie the side that was not served last wins.
    always_comb begin
        o_winner = REQ_IP;
        if (i_req_ip && i_req_arp) begin
            o_winner = (last_q == REQ_IP) ? REQ_ARP : REQ_IP;
        end else if (i_req_arp) begin
            o_winner = REQ_ARP;
        end
    end

    // Pointer resets to "ARP served last" so IP wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= REQ_ARP;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mac_tx_arbiter
// Shares the MAC TX datapath between IP and ARP, one whole frame at a time.
// FSM IDLE -> XFER -> GAP -> IDLE; round-robin on ties; the granted byte
// stream is passed to MAC TX through a one-cycle registered mux, and frame
// type/length are latched at grant time.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_ip_*  / i_arp_*              req/type/len/data/valid/last per requester
//   o_ip_grant / o_arp_grant       ownership levels (never both high)
//   o_mac_type/len/data/valid/last frame to MAC TX
//   i_mac_ready                    MAC TX can start a new frame
//   o_busy                         FSM not in IDLE
//   o_timeout                      watchdog abort pulse
// Optional feature macro: MAC_TX_ARB_TIMEOUT_EN enables the XFER watchdog;
// without it o_timeout is constant 0 and XFER waits for last indefinitely.
// ---------------------------------------------------------------------------
module mac_tx_arbiter
    import mac_stack_pkg::*;
#(
    parameter int P_GAP_CYCLES = 12,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ip_req,
    input  logic [15:0] i_ip_type,
    input  logic [15:0] i_ip_len,
    input  logic [7:0]  i_ip_data,
    input  logic        i_ip_valid,
    input  logic        i_ip_last,
    output logic        o_ip_grant,
    input  logic        i_arp_req,
    input  logic [15:0] i_arp_type,
    input  logic [15:0] i_arp_len,
    input  logic [7:0]  i_arp_data,
    input  logic        i_arp_valid,
    input  logic        i_arp_last,
    output logic        o_arp_grant,
    output logic [15:0] o_mac_type,
    output logic [15:0] o_mac_len,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_valid,
    output logic        o_mac_last,
    input  logic        i_mac_ready,
    output logic        o_busy,
    output logic        o_timeout
);

    logic [1:0]  state_q,   state_d;
    logic        owner_q,   owner_d;
    logic [15:0] type_q,    type_d;
    logic [15:0] len_q,     len_d;
    logic [7:0]  data_q,    data_d;
    logic        valid_q,   valid_d;
    logic        last_q,    last_d;
    logic [7:0]  gap_q,     gap_d;
    logic        timeout_q, timeout_d;

    logic        arb_winner;
    logic        frame_end;
    logic        in_xfer;
    logic        g_valid;
    logic        g_last;
    logic [7:0]  g_data;
    logic        wd_expire;

    assign in_xfer = (state_q == ST_XFER);

    // Beat from the current owner; the other side's inputs never reach MAC TX.
    assign g_valid = in_xfer && ((owner_q == REQ_IP) ? i_ip_valid : i_arp_valid);
    assign g_last  = (owner_q == REQ_IP) ? i_ip_last : i_arp_last;
    assign g_data  = (owner_q == REQ_IP) ? i_ip_data : i_arp_data;

    rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req_ip  (i_ip_req),
        .i_req_arp (i_arp_req),
        .i_update  (frame_end),
        .i_served  (owner_q),
        .o_winner  (arb_winner)
    );

`ifdef MAC_TX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(P_TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counts consecutive XFER cycles without an owner beat; the cycle that
    // would make the count reach P_TIMEOUT is the abort cycle.
    assign wd_expire = in_xfer && !g_valid && (wd_q == WD_W'(P_TIMEOUT - 1));

    always_comb begin
        wd_d = '0;
        if (in_xfer && !g_valid && !wd_expire) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        type_d    = type_q;
        len_d     = len_q;
        data_d    = 8'h00;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_mac_ready && (i_ip_req || i_arp_req)) begin
                    state_d = ST_XFER;
                    owner_d = arb_winner;
                    type_d  = (arb_winner == REQ_IP) ? i_ip_type : i_arp_type;
                    len_d   = (arb_winner == REQ_IP) ? i_ip_len  : i_arp_len;
                end
            end
            ST_XFER: begin
                data_d  = g_data;
                valid_d = g_valid;
                last_d  = g_valid && g_last;
                if (g_valid && g_last) begin
                    frame_end = 1'b1;
                    state_d   = ST_GAP;
                    gap_d     = 8'd0;
                end else if (wd_expire) begin
                    // Close the frame on the MAC side with a dummy last byte.
                    data_d    = 8'h00;
                    valid_d   = 1'b1;
                    last_d    = 1'b1;
                    timeout_d = 1'b1;
                    frame_end = 1'b1;
                    state_d   = ST_GAP;
                    gap_d     = 8'd0;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'(P_GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= REQ_IP;
            type_q    <= 16'h0000;
            len_q     <= 16'h0000;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            gap_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            type_q    <= type_d;
            len_q     <= len_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    // Grants decode straight from flops, so they are exclusive by construction.
    assign o_ip_grant  = in_xfer && (owner_q == REQ_IP);
    assign o_arp_grant = in_xfer && (owner_q == REQ_ARP);
    assign o_mac_type  = type_q;
    assign o_mac_len   = len_q;
    assign o_mac_data  = data_q;
    assign o_mac_valid = valid_q;
    assign o_mac_last  = last_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_arbiter
// Directed test bench for mac_tx_arbiter. Expected values are hand-derived
// from the arbiter's timing: grant one edge after IDLE sees ready & req,
// MAC beats one edge behind the granted input, next grant GAP+1 edges after
// the edge that shows o_mac_last.
// ---------------------------------------------------------------------------
module tb_mac_tx_arbiter;
    import mac_stack_pkg::*;

    localparam int GAP = 12;
    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_ip_req = 1'b0, i_arp_req = 1'b0;
    logic [15:0] i_ip_type = '0, i_ip_len = '0, i_arp_type = '0, i_arp_len = '0;
    logic [7:0]  i_ip_data = '0, i_arp_data = '0;
    logic        i_ip_valid = 1'b0, i_ip_last = 1'b0;
    logic        i_arp_valid = 1'b0, i_arp_last = 1'b0;
    logic        i_mac_ready = 1'b0;
    logic        o_ip_grant, o_arp_grant, o_mac_valid, o_mac_last, o_busy, o_timeout;
    logic [15:0] o_mac_type, o_mac_len;
    logic [7:0]  o_mac_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] t1_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    mac_tx_arbiter #(
        .P_GAP_CYCLES (GAP),
        .P_TIMEOUT    (TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ip_req    (i_ip_req),
        .i_ip_type   (i_ip_type),
        .i_ip_len    (i_ip_len),
        .i_ip_data   (i_ip_data),
        .i_ip_valid  (i_ip_valid),
        .i_ip_last   (i_ip_last),
        .o_ip_grant  (o_ip_grant),
        .i_arp_req   (i_arp_req),
        .i_arp_type  (i_arp_type),
        .i_arp_len   (i_arp_len),
        .i_arp_data  (i_arp_data),
        .i_arp_valid (i_arp_valid),
        .i_arp_last  (i_arp_last),
        .o_arp_grant (o_arp_grant),
        .o_mac_type  (o_mac_type),
        .o_mac_len   (o_mac_len),
        .o_mac_data  (o_mac_data),
        .o_mac_valid (o_mac_valid),
        .o_mac_last  (o_mac_last),
        .i_mac_ready (i_mac_ready),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ip_grant"},  32'(o_ip_grant),  0);
        chk({tag, "_arp_grant"}, 32'(o_arp_grant), 0);
        chk({tag, "_type"},      32'(o_mac_type),  0);
        chk({tag, "_len"},       32'(o_mac_len),   0);
        chk({tag, "_data"},      32'(o_mac_data),  0);
        chk({tag, "_valid"},     32'(o_mac_valid), 0);
        chk({tag, "_last"},      32'(o_mac_last),  0);
        chk({tag, "_busy"},      32'(o_busy),      0);
        chk({tag, "_timeout"},   32'(o_timeout),   0);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300 && o_busy; k++) tick();
        chk({tag, "_idle"}, 32'(o_busy), 0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int  k;
        logic seen;

        // ---------------- reset state ----------------
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("rst");
        tick();
        i_rst_n = 1'b1;
        i_mac_ready = 1'b1;

        // ---------------- 1 + 3: IP alone, ARP spuriously valid ----------------
        i_ip_req = 1'b1; i_ip_type = P_TYPE_IP; i_ip_len = 16'd4;
        i_arp_valid = 1'b1; i_arp_data = 8'hAA; i_arp_last = 1'b1;
        #1;
        chk("t1_no_grant_yet", 32'(o_ip_grant), 0);
        tick();
        chk("t1_ip_grant",  32'(o_ip_grant),  1);
        chk("t1_arp_grant", 32'(o_arp_grant), 0);
        chk("t1_type",      32'(o_mac_type),  32'h0800);
        chk("t1_len",       32'(o_mac_len),   4);
        chk("t1_busy",      32'(o_busy),      1);
        chk("t1_valid0",    32'(o_mac_valid), 0);
        i_ip_req = 1'b0; i_ip_type = 16'hFFFF; i_ip_len = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            i_ip_valid = 1'b1; i_ip_data = t1_bytes[i]; i_ip_last = (i == 3);
            tick();
            chk($sformatf("t1_data%0d", i),  32'(o_mac_data),  32'(t1_bytes[i]));
            chk($sformatf("t1_valid%0d", i), 32'(o_mac_valid), 1);
            chk($sformatf("t1_last%0d", i),  32'(o_mac_last),  (i == 3) ? 1 : 0);
        end
        i_ip_valid = 1'b0; i_ip_last = 1'b0;
        chk("t1_grant_dropped", 32'(o_ip_grant), 0);
        chk("t1_type_held",     32'(o_mac_type), 32'h0800);
        chk("t1_len_held",      32'(o_mac_len),  4);
        chk("t1_no_timeout",    32'(o_timeout),  0);
        tick();
        chk("t1_valid_after", 32'(o_mac_valid), 0);
        chk("t1_in_gap_busy", 32'(o_busy),      1);
        i_arp_valid = 1'b0; i_arp_last = 1'b0; i_arp_data = 8'h00;

        // ---------------- 2: simultaneous requests after reset ----------------
        do_reset();
        i_ip_req = 1'b1;  i_ip_type = P_TYPE_IP;   i_ip_len = 16'd2;
        i_arp_req = 1'b1; i_arp_type = P_TYPE_ARP; i_arp_len = 16'd28;
        tick();
        chk("t2_ip_first",  32'(o_ip_grant),  1);
        chk("t2_arp_wait",  32'(o_arp_grant), 0);
        i_ip_req = 1'b0;
        i_ip_valid = 1'b1; i_ip_data = 8'hA1;
        tick();
        chk("t2_dataA1", 32'(o_mac_data), 32'hA1);
        i_ip_valid = 1'b0;
        tick();
        chk("t2_bubble_valid", 32'(o_mac_valid), 0);
        i_ip_valid = 1'b1; i_ip_data = 8'hA2; i_ip_last = 1'b1;
        tick();
        chk("t2_dataA2", 32'(o_mac_data), 32'hA2);
        chk("t2_last",   32'(o_mac_last), 1);
        i_ip_valid = 1'b0; i_ip_last = 1'b0;
        k = 0;
        while (k < 40 && !o_arp_grant) begin
            tick();
            k++;
        end
        chk("t2_gap_to_arp_grant", 32'(k), 32'(GAP + 1));
        chk("t2_ip_not_granted",   32'(o_ip_grant), 0);
        chk("t2_arp_type",         32'(o_mac_type), 32'h0806);
        chk("t2_arp_len",          32'(o_mac_len),  28);
        // IP drives a bogus last beat while ARP owns the datapath.
        i_arp_req = 1'b0;
        i_ip_valid = 1'b1; i_ip_data = 8'hAA; i_ip_last = 1'b1;
        i_arp_valid = 1'b1; i_arp_data = 8'h5A; i_arp_last = 1'b1;
        tick();
        chk("t2_arp_data", 32'(o_mac_data), 32'h5A);
        chk("t2_arp_last", 32'(o_mac_last), 1);
        i_ip_valid = 1'b0; i_ip_last = 1'b0;
        i_arp_valid = 1'b0; i_arp_last = 1'b0;

        // Tie after ARP was served -> IP; tie after IP was served -> ARP.
        wait_idle("t2a");
        i_ip_req = 1'b1; i_arp_req = 1'b1;
        tick();
        chk("t2_tie1_ip", 32'(o_ip_grant), 1);
        i_ip_valid = 1'b1; i_ip_data = 8'h01; i_ip_last = 1'b1;
        tick();
        i_ip_valid = 1'b0; i_ip_last = 1'b0;
        k = 0;
        while (k < 40 && !(o_ip_grant || o_arp_grant)) begin
            tick();
            k++;
        end
        chk("t2_tie2_arp", 32'(o_arp_grant), 1);
        chk("t2_tie2_ip",  32'(o_ip_grant),  0);
        i_ip_req = 1'b0; i_arp_req = 1'b0;
        i_arp_valid = 1'b1; i_arp_data = 8'h02; i_arp_last = 1'b1;
        tick();
        i_arp_valid = 1'b0; i_arp_last = 1'b0;

        // ---------------- 4: MAC not ready ----------------
        wait_idle("t4");
        i_mac_ready = 1'b0;
        i_ip_req = 1'b1; i_ip_type = P_TYPE_IP; i_ip_len = 16'd1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            seen = seen | o_ip_grant | o_arp_grant | o_busy;
        end
        chk("t4_no_grant_50", 32'(seen), 0);
        i_mac_ready = 1'b1;
        tick();
        chk("t4_grant_after_ready", 32'(o_ip_grant), 1);
        i_ip_req = 1'b0;
        i_ip_valid = 1'b1; i_ip_data = 8'h77; i_ip_last = 1'b1;
        tick();
        i_ip_valid = 1'b0; i_ip_last = 1'b0;

        // ---------------- 5: async reset mid-frame ----------------
        wait_idle("t5");
        i_ip_req = 1'b1; i_ip_len = 16'd10;
        tick();
        chk("t5_grant", 32'(o_ip_grant), 1);
        i_ip_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_ip_valid = 1'b1; i_ip_data = 8'(i + 1);
            tick();
        end
        chk("t5_byte3_out", 32'(o_mac_data), 3);
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        i_ip_valid = 1'b0;
        i_ip_req = 1'b1; i_arp_req = 1'b1;
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("t5_tie_ip",  32'(o_ip_grant),  1);
        chk("t5_tie_arp", 32'(o_arp_grant), 0);
        i_ip_req = 1'b0; i_arp_req = 1'b0;
        i_ip_valid = 1'b1; i_ip_data = 8'h09; i_ip_last = 1'b1;
        tick();
        chk("t5_end_last", 32'(o_mac_last), 1);
        i_ip_valid = 1'b0; i_ip_last = 1'b0;

`ifdef MAC_TX_ARB_TIMEOUT_EN
        // ---------------- 6: watchdog abort ----------------
        wait_idle("t6");
        i_ip_req = 1'b1;
        tick();
        chk("t6_grant", 32'(o_ip_grant), 1);
        i_ip_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            seen = seen | o_mac_valid | o_timeout | !o_ip_grant;
        end
        chk("t6_quiet", 32'(seen), 0);
        tick();
        chk("t6_valid",   32'(o_mac_valid), 1);
        chk("t6_last",    32'(o_mac_last),  1);
        chk("t6_data",    32'(o_mac_data),  0);
        chk("t6_timeout", 32'(o_timeout),   1);
        chk("t6_grant0",  32'(o_ip_grant),  0);
        tick();
        chk("t6_pulse_end", 32'(o_timeout),   0);
        chk("t6_valid_end", 32'(o_mac_valid), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
